// File: rtl/nios_mul_seq_arb.sv
// Two-requester 32x32 (low word) multiplier sequenced over a shared 16x16 registered cell.
// Define MUL_SEQ_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module nios_mul_seq_arb #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             resp0_valid,
  output logic             resp1_valid,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic [15:0]      mul_a,
  output logic [15:0]      mul_b,
  output logic             mul_en,
  input  logic [31:0]      mul_p,
  output logic             busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISS_LL   = 3'd1,
    ISS_LH   = 3'd2,
    ISS_HL   = 3'd3,
    ACC_LAST = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [TAG_W-1:0]    r_tag;
  logic                r_id;
  logic [DATA_W-1:0]   r_acc;
  logic                r_mul_en;
  logic [HALF_W-1:0]   r_mul_a;
  logic [HALF_W-1:0]   r_mul_b;
  logic                r_resp0_valid;
  logic                r_resp1_valid;
  logic [DATA_W-1:0]   r_resp_data;
  logic [TAG_W-1:0]    r_resp_tag;
  logic                r_busy;

  logic                w_idle;
  logic                w_grant0;
  logic                w_grant1;
  logic                w_accept;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [TAG_W-1:0]    w_sel_tag;
  logic [DATA_W-1:0]   w_acc_next;

`ifdef MUL_SEQ_ARB_RR_EN
  // r_ptr names the requester that wins when both are valid
  logic r_ptr;

  always_comb begin
    w_grant0 = req0_valid && (!r_ptr || !req1_valid);
    w_grant1 = req1_valid && (r_ptr || !req0_valid);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ptr <= 1'b0;
    end else if (w_accept) begin
      r_ptr <= ~r_ptr;
    end
  end
`else
  always_comb begin
    w_grant0 = req0_valid;
    w_grant1 = req1_valid && !req0_valid;
  end
`endif

  // Ready is held low while reset is asserted so nothing can be accepted under reset
  assign w_idle     = (r_state == IDLE) && reset_n;
  assign req0_ready = w_idle && w_grant0;
  assign req1_ready = w_idle && w_grant1;
  assign w_accept   = req0_ready || req1_ready;

  assign w_sel_a    = req1_ready ? req1_a   : req0_a;
  assign w_sel_b    = req1_ready ? req1_b   : req0_b;
  assign w_sel_tag  = req1_ready ? req1_tag : req0_tag;

  // Cross products land on bit 16; overflow past bit 31 is dropped by the adder width
  assign w_acc_next = r_acc + (mul_p << HALF_W);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_tag         <= '0;
      r_id          <= 1'b0;
      r_acc         <= '0;
      r_mul_en      <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp_data   <= '0;
      r_resp_tag    <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_mul_en      <= 1'b0;
      r_mul_a       <= '0;
      r_mul_b       <= '0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_resp_data   <= '0;
      r_resp_tag    <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state  <= ISS_LL;
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_tag    <= w_sel_tag;
            r_id     <= req1_ready;
            r_acc    <= '0;
            r_busy   <= 1'b1;
            r_mul_en <= 1'b1;
            r_mul_a  <= w_sel_a[HALF_W-1:0];
            r_mul_b  <= w_sel_b[HALF_W-1:0];
          end
        end
        ISS_LL: begin
          r_state  <= ISS_LH;
          r_mul_en <= 1'b1;
          r_mul_a  <= r_a[HALF_W-1:0];
          r_mul_b  <= r_b[DATA_W-1:HALF_W];
        end
        ISS_LH: begin
          r_state  <= ISS_HL;
          r_acc    <= mul_p;
          r_mul_en <= 1'b1;
          r_mul_a  <= r_a[DATA_W-1:HALF_W];
          r_mul_b  <= r_b[HALF_W-1:0];
        end
        ISS_HL: begin
          r_state <= ACC_LAST;
          r_acc   <= w_acc_next;
        end
        ACC_LAST: begin
          r_state       <= DONE;
          r_acc         <= w_acc_next;
          r_resp_data   <= w_acc_next;
          r_resp_tag    <= r_tag;
          r_resp0_valid <= !r_id;
          r_resp1_valid <= r_id;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mul_en      = r_mul_en;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign resp_data   = r_resp_data;
  assign resp_tag    = r_resp_tag;
  assign busy        = r_busy;

endmodule

// File: doc/nios_mul_seq_arb.md
NIOS_MUL_SEQ_ARB -- requirements
Module: nios_mul_seq_arb

Interface
REQ-001 The block SHALL have parameter TAG_W, default 4: width of the requester tag echoed on the response.
REQ-002 The block SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-004 The block SHALL have ports req0_valid/req1_valid, input, 1 each: multiply request from requester 0/1.
REQ-005 The block SHALL have ports req0_ready/req1_ready, output, 1 each: request accepted this cycle when valid and ready are both high.
REQ-006 The block SHALL have ports req0_a/req0_b and req1_a/req1_b, input, 32 each: operands.
REQ-007 The block SHALL have ports req0_tag/req1_tag, input, TAG_W each: opaque tag.
REQ-008 The block SHALL have ports resp0_valid/resp1_valid, output, 1 each: single-cycle result pulse.
REQ-009 The block SHALL have port resp_data, output, 32, and port resp_tag, output, TAG_W: shared result and tag, qualified by respN_valid.
REQ-010 The block SHALL have ports mul_a/mul_b, output, 16 each, and mul_en, output, 1: operands and enable to the shared unsigned 16x16 registered multiplier cell.
REQ-011 The block SHALL have port mul_p, input, 32: cell product.
- mul_p is valid the cycle after mul_en=1.
- mul_p holds its value while mul_en=0.
REQ-012 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-013 The block SHALL compute the low 32 bits of the unsigned product a*b, modulo 2^32, as a[15:0]*b[15:0] + ((a[15:0]*b[31:16] + a[31:16]*b[15:0]) << 16).
REQ-014 The block SHALL implement FSM states IDLE, ISS_LL, ISS_LH, ISS_HL, ACC_LAST and DONE.
REQ-015 The FSM SHALL follow this sequence:
- IDLE -> ISS_LL on accept.
- ISS_LL -> ISS_LH -> ISS_HL -> ACC_LAST -> DONE -> IDLE, one cycle per step, unconditionally.
REQ-016 In IDLE, the block SHALL assert exactly one reqN_ready, for the granted requester, and only when that requester's reqN_valid=1.
- Grant is combinational.
- Both ready outputs SHALL be 0 in all other states.
REQ-017 On accept, the block SHALL latch operands, tag and requester ID, and clear the 32-bit accumulator.
REQ-018 mul_en SHALL be 1 in ISS_LL, ISS_LH and ISS_HL, and 0 in all other states.
- ISS_LL drives mul_a/mul_b = a[15:0]/b[15:0].
- ISS_LH drives a[15:0]/b[31:16].
- ISS_HL drives a[31:16]/b[15:0].
- mul_a/mul_b SHALL be 0 in all other states.
REQ-019 Accumulation SHALL be modulo 2^32, with bits above 31 discarded:
- In ISS_LH, acc <= mul_p.
- In ISS_HL, acc <= acc + (mul_p << 16).
- In ACC_LAST, acc <= acc + (mul_p << 16).
REQ-020 In DONE, the block SHALL drive resp_data=acc and resp_tag=latched tag, and pulse the latched requester's respN_valid for exactly one cycle.
- Responses have no backpressure.
REQ-021 Latency SHALL be fixed: accept at cycle T gives respN_valid at T+5.
- The earliest next accept is at T+6.
- Throughput is one operation per 6 cycles.
REQ-022 Outside DONE, resp_data and resp_tag SHALL be 0.
REQ-023 A requester SHALL be able to hold valid across cycles without being accepted twice.
- Acceptance occurs only on a valid&&ready cycle.
REQ-024 Operand changes on req inputs after accept SHALL NOT affect the in-flight result.

Reset
REQ-025 When reset_n=0 at a rising edge, the block SHALL:
- enter IDLE;
- clear the accumulator, latched operands, tag and ID;
- drive req*_ready=0, resp*_valid=0, resp_data=0, resp_tag=0, mul_en=0, mul_a=0, mul_b=0 and busy=0.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no response, and the round-robin pointer SHALL reset to favour requester 0.
REQ-027 The block SHALL be able to accept a request in the first cycle after reset_n returns to 1.

Configuration
REQ-028 When macro MUL_SEQ_ARB_RR_EN is defined, arbitration SHALL be round-robin.
- A 1-bit pointer selects the priority requester and toggles to the other requester on each accept.
- With both requesters valid continuously, grants alternate 0,1,0,1...
REQ-029 When MUL_SEQ_ARB_RR_EN is undefined, arbitration SHALL be fixed priority with requester 0 always winning, and no pointer register SHALL exist.

Verification
REQ-030 Req0 a=3, b=5, tag=2 -> resp0_valid at T+5, resp_data=15, resp_tag=2, mul_en high for exactly 3 cycles.
REQ-031 Req1 a=b=0xFFFFFFFF -> resp_data=0x00000001; a=0x00010000, b=0x00010000 -> resp_data=0x00000000; a=0x12345678, b=0x9ABCDEF0 -> resp_data=0x242D2080.
REQ-032 Both valid continuously for 4 operations:
- With MUL_SEQ_ARB_RR_EN, resp order is 0,1,0,1.
- Without it, resp order is 0,0,0,0 and req1_ready is never 1.
REQ-033 reset_n=0 for one cycle in ISS_HL -> no respN_valid; state IDLE, busy=0 next cycle; new req0 a=7, b=6 after reset -> resp_data=42.
REQ-034 Req0 valid held during a busy operation with operands changed mid-flight -> the first result is unaffected, and req0 is accepted exactly once at the next IDLE.
